// File: rtl/dac_frame_gen_pkg.sv
// dac_frame_gen_pkg: shared types and helpers for the DAC frame generator.
//   mode_t    - sample source selection (value 3 is decoded as constant)
//   state_t   - generator run state
//   sel_width - width of the channel-select field for a given channel count
package dac_frame_gen_pkg;

  typedef enum logic [1:0] {
    MODE_RAMP   = 2'd0,
    MODE_CONST  = 2'd1,
    MODE_STREAM = 2'd2
  } mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int unsigned sel_width(input int unsigned n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/dac_frame_gen_if.sv
// dac_frame_gen_if: control, stream and DAC pin bundle of the frame generator.
//   slave  - generator side: takes control/stream inputs, drives DAC pins
//   master - driver side (system / testbench)
// Signals: en, mode, step, const_val, s_data, s_valid, s_ready,
//          dac_clk, dac_dout, dac_sel, frame_start, underflow.
interface dac_frame_gen_if import dac_frame_gen_pkg::*; #(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned N_CH   = 2
);
  localparam int unsigned SEL_W = sel_width(N_CH);

  logic                   en;
  logic [1:0]             mode;
  logic [DATA_W-1:0]      step;
  logic [DATA_W-1:0]      const_val;
  logic [N_CH*DATA_W-1:0] s_data;
  logic                   s_valid;
  logic                   s_ready;
  logic                   dac_clk;
  logic [DATA_W-1:0]      dac_dout;
  logic [SEL_W-1:0]       dac_sel;
  logic                   frame_start;
  logic                   underflow;

  modport slave (
    input  en, mode, step, const_val, s_data, s_valid,
    output s_ready, dac_clk, dac_dout, dac_sel, frame_start, underflow
  );

  modport master (
    output en, mode, step, const_val, s_data, s_valid,
    input  s_ready, dac_clk, dac_dout, dac_sel, frame_start, underflow
  );

endinterface

// File: rtl/dac_sync_fifo.sv
// dac_sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, rst_n - clock and asynchronous active-low reset (flushes contents)
//   push, din  - write request and data (ignored while full)
//   pop        - read request (ignored while empty)
//   dout       - head entry, valid whenever !empty
//   full/empty - occupancy flags
module dac_sync_fifo #(
  parameter int unsigned WIDTH = 28,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit tells full from empty when the indices match.
  logic [AW:0]      wptr_q, rptr_q;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign dout  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push && !full)  wptr_q <= wptr_q + (AW+1)'(1);
      if (pop  && !empty) rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/dac_frame_gen.sv
// dac_frame_gen: divides clk into a DAC sample clock and time-multiplexes N_CH
// channels per frame onto one DAC bus. Frames come from a ramp, a constant or
// a streamed FIFO.
//   clk, rst_n - system clock, asynchronous active-low reset
//   bus        - dac_frame_gen_if.slave: en/mode/step/const_val controls,
//                s_data/s_valid/s_ready stream input, dac_clk/dac_dout/dac_sel
//                DAC pins, frame_start and underflow status pulses
module dac_frame_gen import dac_frame_gen_pkg::*; #(
  parameter int unsigned DATA_W     = 14,
  parameter int unsigned CLK_DIV    = 8,
  parameter int unsigned N_CH       = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  dac_frame_gen_if.slave bus
);
  localparam int unsigned SEL_W = sel_width(N_CH);
  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned FW    = N_CH * DATA_W;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [SEL_W-1:0] SLOT_LAST = SEL_W'(N_CH - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  slot_q, slot_d, next_slot;
  logic [DATA_W-1:0] ramp_q, ramp_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic              dac_clk_q, dac_clk_d;
  logic [DATA_W-1:0] dac_dout_q, dac_dout_d;
  logic [SEL_W-1:0]  dac_sel_q, dac_sel_d;
  logic              frame_start_q, frame_start_d;
  logic              underflow_q, underflow_d;
  logic              fetch;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]     fifo_dout;

  assign fifo_push = bus.s_valid && !fifo_full;
  assign next_slot = slot_q + SEL_W'(1);

  dac_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (bus.s_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    slot_d        = slot_q;
    ramp_d        = ramp_q;
    frame_d       = frame_q;
    dac_clk_d     = dac_clk_q;
    dac_dout_d    = dac_dout_q;
    dac_sel_d     = dac_sel_q;
    frame_start_d = 1'b0;
    underflow_d   = 1'b0;
    fifo_pop      = 1'b0;
    fetch         = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d     = '0;
        dac_clk_d = 1'b0;
        if (bus.en) begin
          fetch   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        if (cnt_q == CNT_HALF) dac_clk_d = 1'b1;
        // Slot boundary: data only moves with the falling dac_clk edge.
        if (cnt_q == CNT_LAST) begin
          dac_clk_d = 1'b0;
          if (slot_q != SLOT_LAST) begin
            slot_d     = next_slot;
            dac_dout_d = frame_q[32'(next_slot) * DATA_W +: DATA_W];
            dac_sel_d  = next_slot;
          end else if (bus.en) begin
            fetch = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (fetch) begin
      case (mode_t'(bus.mode))
        MODE_RAMP: begin
          frame_d = {N_CH{ramp_q}};
          ramp_d  = ramp_q + bus.step;
        end
        MODE_STREAM: begin
          // On underflow the previous frame is replayed.
          if (!fifo_empty) begin
            frame_d  = fifo_dout;
            fifo_pop = 1'b1;
          end else begin
            underflow_d = 1'b1;
          end
        end
        default: frame_d = {N_CH{bus.const_val}};
      endcase
      dac_dout_d    = frame_d[DATA_W-1:0];
      dac_sel_d     = '0;
      slot_d        = '0;
      frame_start_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      slot_q        <= '0;
      ramp_q        <= '0;
      frame_q       <= '0;
      dac_clk_q     <= 1'b0;
      dac_dout_q    <= '0;
      dac_sel_q     <= '0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      slot_q        <= slot_d;
      ramp_q        <= ramp_d;
      frame_q       <= frame_d;
      dac_clk_q     <= dac_clk_d;
      dac_dout_q    <= dac_dout_d;
      dac_sel_q     <= dac_sel_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
    end
  end

  assign bus.s_ready     = !fifo_full;
  assign bus.dac_clk     = dac_clk_q;
  assign bus.dac_dout    = dac_dout_q;
  assign bus.dac_sel     = dac_sel_q;
  assign bus.frame_start = frame_start_q;
  assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_dac_frame_gen.sv
// tb_dac_frame_gen: self-checking bench for dac_frame_gen. A frame-level model
// (time since fetch, frame contents, FIFO queue) predicts every output each
// cycle; table vectors and hand sequences add explicit value checks.
module tb_dac_frame_gen;
  import dac_frame_gen_pkg::*;

  localparam int unsigned DATA_W     = 14;
  localparam int unsigned CLK_DIV    = 8;
  localparam int unsigned N_CH       = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned FW         = N_CH * DATA_W;
  localparam int unsigned FRAME_CLKS = N_CH * CLK_DIV;
  localparam int unsigned MASK       = (1 << DATA_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dac_frame_gen_if #(.DATA_W(DATA_W), .N_CH(N_CH)) bus ();

  dac_frame_gen #(
    .DATA_W     (DATA_W),
    .CLK_DIV    (CLK_DIV),
    .N_CH       (N_CH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model state: valid after the most recent clock edge.
  bit            m_run;
  int unsigned   m_t;
  int unsigned   m_frame [N_CH];
  int unsigned   m_ramp;
  logic [FW-1:0] m_fifo [$];
  int unsigned   m_dout, m_sel;
  bit            m_fs, m_uf;

  // Observation recorders.
  int unsigned seen [$];
  int unsigned rise_t [$];
  int unsigned fs_t [$];
  int unsigned uf_cnt;
  int unsigned cyc;
  bit          prev_clk;

  task automatic model_reset();
    m_run = 0; m_t = 0; m_ramp = 0; m_dout = 0; m_sel = 0; m_fs = 0; m_uf = 0;
    for (int k = 0; k < N_CH; k++) m_frame[k] = 0;
    m_fifo.delete();
  endtask

  task automatic clear_rec();
    seen.delete(); rise_t.delete(); fs_t.delete();
    uf_cnt = 0; prev_clk = 0;
  endtask

  // Predict the effect of the coming clock edge from the current inputs.
  task automatic model_step();
    bit            push_ok;
    logic [FW-1:0] pushed;
    logic [FW-1:0] f;
    push_ok = bus.s_valid && (m_fifo.size() < FIFO_DEPTH);
    pushed  = bus.s_data;
    m_fs = 0;
    m_uf = 0;
    if (!m_run || m_t == FRAME_CLKS - 1) begin
      if (bus.en) begin
        case (bus.mode)
          2'd0: begin
            for (int k = 0; k < N_CH; k++) m_frame[k] = m_ramp;
            m_ramp = (m_ramp + 32'(bus.step)) & MASK;
          end
          2'd2: begin
            if (m_fifo.size() > 0) begin
              f = m_fifo.pop_front();
              for (int k = 0; k < N_CH; k++) m_frame[k] = 32'(f[k*DATA_W +: DATA_W]);
            end else begin
              m_uf = 1;
            end
          end
          default: for (int k = 0; k < N_CH; k++) m_frame[k] = 32'(bus.const_val);
        endcase
        m_run = 1; m_t = 0; m_fs = 1; m_dout = m_frame[0]; m_sel = 0;
      end else begin
        m_run = 0;
      end
    end else begin
      m_t++;
      if (m_t % CLK_DIV == 0) begin
        m_sel  = m_t / CLK_DIV;
        m_dout = m_frame[m_sel];
      end
    end
    if (push_ok) m_fifo.push_back(pushed);
  endtask

  task automatic compare();
    chk("dac_dout", 32'(bus.dac_dout), m_dout);
    chk("dac_sel", 32'(bus.dac_sel), m_sel);
    chk("dac_clk", 32'(bus.dac_clk), 32'(m_run && (m_t % CLK_DIV) >= CLK_DIV / 2));
    chk("frame_start", 32'(bus.frame_start), 32'(m_fs));
    chk("underflow", 32'(bus.underflow), 32'(m_uf));
    chk("s_ready", 32'(bus.s_ready), 32'(m_fifo.size() < FIFO_DEPTH));
    if (bus.dac_clk && !prev_clk) begin
      seen.push_back(32'(bus.dac_dout));
      rise_t.push_back(cyc);
    end
    if (bus.frame_start) fs_t.push_back(cyc);
    if (bus.underflow) uf_cnt++;
    prev_clk = bus.dac_clk;
    cyc++;
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".dac_clk"}, 32'(bus.dac_clk), 0);
    chk({tag, ".dac_dout"}, 32'(bus.dac_dout), 0);
    chk({tag, ".dac_sel"}, 32'(bus.dac_sel), 0);
    chk({tag, ".frame_start"}, 32'(bus.frame_start), 0);
    chk({tag, ".underflow"}, 32'(bus.underflow), 0);
    chk({tag, ".s_ready"}, 32'(bus.s_ready), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.en = 1'b0; bus.mode = 2'd0; bus.step = '0; bus.const_val = '0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_rec();
  endtask

  task automatic check_seen(input string tag, input int unsigned exp [$]);
    chk({tag, ".count"}, seen.size(), exp.size());
    for (int j = 0; j < exp.size(); j++)
      if (j < seen.size()) chk($sformatf("%s.slot%0d", tag, j), seen[j], exp[j]);
  endtask

  typedef struct packed {
    logic [1:0]              mode;
    logic [DATA_W-1:0]       step;
    logic [DATA_W-1:0]       cval;
    logic [5:0][DATA_W-1:0]  exp;
    logic [3:0]              uf;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] m, input int unsigned st, input int unsigned cv,
                              input int unsigned e0, input int unsigned e1,
                              input int unsigned e2, input int unsigned e3,
                              input int unsigned e4, input int unsigned e5,
                              input int unsigned uf);
    vec_t v;
    v.mode = m;
    v.step = DATA_W'(st);
    v.cval = DATA_W'(cv);
    v.exp[0] = DATA_W'(e0); v.exp[1] = DATA_W'(e1); v.exp[2] = DATA_W'(e2);
    v.exp[3] = DATA_W'(e3); v.exp[4] = DATA_W'(e4); v.exp[5] = DATA_W'(e5);
    v.uf = 4'(uf);
    return v;
  endfunction

  function automatic logic [FW-1:0] sframe(input int unsigned f);
    logic [FW-1:0] d;
    for (int k = 0; k < N_CH; k++) d[k*DATA_W +: DATA_W] = DATA_W'(32'h100 * (f + 1) + k);
    return d;
  endfunction

  initial begin
    vec_t        tbl [5];
    int unsigned exp [$];
    string       nm;

    tbl[0] = mk(2'd0, 3, 0, 0, 0, 3, 3, 6, 6, 0);
    tbl[1] = mk(2'd1, 0, 'h1ABC, 'h1ABC, 'h1ABC, 'h1ABC, 'h1ABC, 'h1ABC, 'h1ABC, 0);
    tbl[2] = mk(2'd3, 0, 'h0155, 'h155, 'h155, 'h155, 'h155, 'h155, 'h155, 0);
    tbl[3] = mk(2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    tbl[4] = mk(2'd0, 16383, 0, 0, 0, 16383, 16383, 16382, 16382, 0);
    cyc = 0;

    // Reset state, then idle with en low.
    rst_n = 1'b0;
    bus.en = 1'b0; bus.mode = 2'd0; bus.step = '0; bus.const_val = '0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    model_reset();
    clear_rec();
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run(20);

    // Table vectors: three frames from reset per source.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      bus.mode = tbl[i].mode; bus.step = tbl[i].step; bus.const_val = tbl[i].cval;
      bus.en = 1'b1;
      run(48);
      bus.en = 1'b0;
      run(20);
      exp.delete();
      for (int j = 0; j < 6; j++) exp.push_back(32'(tbl[i].exp[j]));
      nm = $sformatf("vec%0d", i);
      check_seen(nm, exp);
      chk({nm, ".underflows"}, uf_cnt, 32'(tbl[i].uf));
    end

    // Ramp timing: dac_clk period, first rise, frame period.
    do_reset();
    bus.step = 14'd3; bus.en = 1'b1;
    run(48);
    chk("timing.frames", fs_t.size(), 3);
    chk("timing.rises", rise_t.size(), 6);
    if (fs_t.size() >= 3 && rise_t.size() >= 3) begin
      chk("timing.frame_period", fs_t[1] - fs_t[0], FRAME_CLKS);
      chk("timing.frame_period2", fs_t[2] - fs_t[1], FRAME_CLKS);
      chk("timing.first_rise", rise_t[0] - fs_t[0], CLK_DIV / 2);
      chk("timing.clk_period", rise_t[2] - rise_t[1], CLK_DIV);
    end
    bus.en = 1'b0;
    run(20);

    // Ramp wrap: 16383 + 3 wraps to 2.
    do_reset();
    bus.step = 14'd16383; bus.en = 1'b1;
    run(1);
    bus.step = 14'd3;
    run(47);
    check_seen("wrap", '{0, 0, 16383, 16383, 2, 2});
    bus.en = 1'b0;
    run(20);

    // Mode switch mid-frame: the ramp frame completes before const takes over.
    do_reset();
    bus.step = 14'd3; bus.en = 1'b1;
    run(8);
    bus.mode = 2'd1; bus.const_val = 14'h1ABC;
    run(40);
    check_seen("modesw", '{0, 0, 'h1ABC, 'h1ABC, 'h1ABC, 'h1ABC});
    bus.en = 1'b0;
    run(20);

    // Stream: fill FIFO while idle, play back, then replay on underflow.
    do_reset();
    for (int f = 0; f < 4; f++) begin
      bus.s_valid = 1'b1; bus.s_data = sframe(f);
      cycle();
    end
    chk("stream.s_ready_full", 32'(bus.s_ready), 0);
    bus.s_data = sframe(7);
    cycle();
    bus.s_valid = 1'b0; bus.mode = 2'd2; bus.en = 1'b1;
    clear_rec();
    prev_clk = bus.dac_clk;
    run(70);
    bus.en = 1'b0;
    run(20);
    check_seen("stream", '{'h100, 'h101, 'h200, 'h201, 'h300, 'h301, 'h400, 'h401,
                           'h400, 'h401});
    chk("stream.underflows", uf_cnt, 1);

    // en drop mid-frame: frame completes, holds last value, restarts at once.
    do_reset();
    bus.step = 14'd5; bus.en = 1'b1;
    run(20);
    chk("endrop.sel_before", 32'(bus.dac_sel), 0);
    bus.en = 1'b0;
    run(20);
    chk("endrop.dac_clk", 32'(bus.dac_clk), 0);
    chk("endrop.dac_dout", 32'(bus.dac_dout), 5);
    chk("endrop.dac_sel", 32'(bus.dac_sel), 1);
    bus.en = 1'b1;
    cycle();
    chk("endrop.refetch", 32'(bus.frame_start), 1);
    chk("endrop.refetch_dout", 32'(bus.dac_dout), 10);
    bus.en = 1'b0;
    run(20);

    // Asynchronous reset mid-run with two frames queued.
    do_reset();
    for (int f = 0; f < 2; f++) begin
      bus.s_valid = 1'b1; bus.s_data = sframe(f);
      cycle();
    end
    bus.s_valid = 1'b0; bus.step = 14'd1; bus.en = 1'b1;
    run(14);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    prev_clk = 0;
    bus.mode = 2'd2;
    cycle();
    chk("midreset.flushed_underflow", 32'(bus.underflow), 1);
    run(20);
    bus.en = 1'b0;
    run(20);

    // Randomized traffic against the model.
    do_reset();
    bus.en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      bus.s_valid = 1'($urandom_range(0, 1));
      bus.s_data  = FW'($urandom);
      if ($urandom_range(0, 19) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) bus.en = ~bus.en;
      if ($urandom_range(0, 49) == 0) bus.step = DATA_W'($urandom);
      if ($urandom_range(0, 49) == 0) bus.const_val = DATA_W'($urandom);
      cycle();
    end
    bus.en = 1'b0; bus.s_valid = 1'b0;
    run(40);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
